// File: rtl/ripple_count_extender.sv
// ripple_count_extender: filters a glitchy 3-bit ripple count and extends it to W bits
//   Clock, Resetn (sync, active-low), Q_in (async ripple count), Clear (sync clear)
//   Count (extended count), Valid, Wrap (7->0 pulse), Err (sticky bad step),
//   Ovf (sticky upper wrap), HEX0/HEX1 (registered active-low 7-seg of Count[7:0])
module ripple_count_extender #(
  parameter int W = 8,
  parameter int STABLE = 2
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic [2:0]   Q_in,
  input  logic         Clear,
  output logic [W-1:0] Count,
  output logic         Valid,
  output logic         Wrap,
  output logic         Err,
  output logic         Ovf,
  output logic [6:0]   HEX0,
  output logic [6:0]   HEX1
);
  typedef enum logic [1:0] {INIT, TRACK, FAULT} state_t;
  state_t state, state_n;
  logic [2:0] s1, s2, f_val, delta;
  logic v1, v2, acc, upd, roll;
  logic [3:0] run;
  logic [W-1:0] count_n;
  logic valid_n, wrap_n, err_n, ovf_n;
  logic [7:0] c8;
  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
  endfunction
  if (W >= 8) begin : g_wide
    assign c8 = Count[7:0];
  end else begin : g_narrow
    assign c8 = 8'(Count);
  end
  // the filter run only counts once s2 carries real samples, so the reset
  // value of the synchronizer can never be accepted as a baseline
  assign acc = run == 4'(STABLE);
  assign delta = f_val - Count[2:0];
  assign upd = state == TRACK && acc && delta == 3'd1;
  assign roll = upd && f_val == 3'd0;
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      s1 <= '0;
      s2 <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      f_val <= '0;
      run <= '0;
    end else begin
      s1 <= Q_in;
      s2 <= s1;
      v1 <= 1'b1;
      v2 <= v1;
      f_val <= s2;
      run <= (Clear || !v2) ? 4'd0 : (run != 4'd0 && s2 == f_val) ? (acc ? run : run + 4'd1) : 4'd1;
    end
  end
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state <= INIT;
      Count <= '0;
      Valid <= 1'b0;
      Wrap <= 1'b0;
      Err <= 1'b0;
      Ovf <= 1'b0;
      HEX0 <= 7'b1000000;
      HEX1 <= 7'b1000000;
    end else begin
      state <= state_n;
      Count <= count_n;
      Valid <= valid_n;
      Wrap <= wrap_n;
      Err <= err_n;
      Ovf <= ovf_n;
      HEX0 <= seg(c8[3:0]);
      HEX1 <= seg(c8[7:4]);
    end
  end
  always_comb begin
    state_n = Clear ? INIT : !acc ? state : state == INIT ? TRACK : (state == TRACK && delta > 3'd1) ? FAULT : state;
  end
  always_comb begin
    count_n = Count;
    valid_n = Valid;
    wrap_n = 1'b0;
    err_n = Err;
    ovf_n = Ovf;
    if (Clear) begin
      count_n = '0;
      valid_n = 1'b0;
      err_n = 1'b0;
      ovf_n = 1'b0;
    end else if (state == INIT && acc) begin
      count_n = {{(W-3){1'b0}}, f_val};
      valid_n = 1'b1;
    end else if (upd) begin
      count_n = {Count[W-1:3] + (W-3)'(roll), f_val};
      wrap_n = roll;
      ovf_n = Ovf | (roll & (&Count[W-1:3]));
    end else if (state == TRACK && acc && delta > 3'd1) begin
      err_n = 1'b1;
    end
  end
endmodule

// File: tb/tb_ripple_count_extender.sv
// tb_ripple_count_extender: directed table-driven check of ripple_count_extender
module tb_ripple_count_extender;
  logic Clock = 1'b0;
  logic Resetn, Clear;
  logic [2:0] Q_in;
  logic [7:0] Count;
  logic Valid, Wrap, Err, Ovf;
  logic [6:0] HEX0, HEX1;
  int n_cmp = 0;
  int n_bad = 0;
  int wraps = 0;
  typedef struct packed {
    logic [2:0] q;
    logic [7:0] cnt;
    logic       wr;
    logic       er;
    logic       ov;
    logic [6:0] h0;
    logic [6:0] h1;
  } vec_t;
  vec_t rows [16];
  ripple_count_extender #(.W(8), .STABLE(2)) dut (
    .Clock(Clock), .Resetn(Resetn), .Q_in(Q_in), .Clear(Clear),
    .Count(Count), .Valid(Valid), .Wrap(Wrap), .Err(Err), .Ovf(Ovf),
    .HEX0(HEX0), .HEX1(HEX1)
  );
  always #5 Clock = ~Clock;
  task automatic tick();
    @(posedge Clock);
    #1;
    if (Wrap) wraps++;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic apply_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      wraps = 0;
      Q_in = rows[i].q;
      repeat (6) tick();
      chk($sformatf("row%0d count", i), Count, rows[i].cnt);
      chk($sformatf("row%0d wraps", i), wraps, rows[i].wr);
      chk($sformatf("row%0d err", i), Err, rows[i].er);
      chk($sformatf("row%0d ovf", i), Ovf, rows[i].ov);
      chk($sformatf("row%0d valid", i), Valid, 1);
      chk($sformatf("row%0d hex0", i), HEX0, rows[i].h0);
      chk($sformatf("row%0d hex1", i), HEX1, rows[i].h1);
    end
  endtask
  initial begin
    rows = '{
      '{3'd4, 8'h04, 1'b0, 1'b0, 1'b0, 7'h19, 7'h40},
      '{3'd5, 8'h05, 1'b0, 1'b0, 1'b0, 7'h12, 7'h40},
      '{3'd6, 8'h06, 1'b0, 1'b0, 1'b0, 7'h02, 7'h40},
      '{3'd7, 8'h07, 1'b0, 1'b0, 1'b0, 7'h78, 7'h40},
      '{3'd0, 8'h08, 1'b1, 1'b0, 1'b0, 7'h00, 7'h40},
      '{3'd1, 8'h09, 1'b0, 1'b0, 1'b0, 7'h10, 7'h40},
      '{3'd2, 8'h0A, 1'b0, 1'b0, 1'b0, 7'h08, 7'h40},
      '{3'd1, 8'hF9, 1'b0, 1'b0, 1'b0, 7'h10, 7'h0E},
      '{3'd2, 8'hFA, 1'b0, 1'b0, 1'b0, 7'h08, 7'h0E},
      '{3'd3, 8'hFB, 1'b0, 1'b0, 1'b0, 7'h03, 7'h0E},
      '{3'd4, 8'hFC, 1'b0, 1'b0, 1'b0, 7'h46, 7'h0E},
      '{3'd5, 8'hFD, 1'b0, 1'b0, 1'b0, 7'h21, 7'h0E},
      '{3'd6, 8'hFE, 1'b0, 1'b0, 1'b0, 7'h06, 7'h0E},
      '{3'd7, 8'hFF, 1'b0, 1'b0, 1'b0, 7'h0E, 7'h0E},
      '{3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 7'h40, 7'h40},
      '{3'd1, 8'h01, 1'b0, 1'b0, 1'b1, 7'h79, 7'h40}
    };
    Resetn = 1'b0;
    Clear = 1'b0;
    Q_in = 3'd3;
    repeat (2) tick();
    chk("rst count", Count, 0);
    chk("rst valid", Valid, 0);
    chk("rst wrap", Wrap, 0);
    chk("rst err", Err, 0);
    chk("rst ovf", Ovf, 0);
    chk("rst hex0", HEX0, 7'h40);
    chk("rst hex1", HEX1, 7'h40);
    Resetn = 1'b1;
    repeat (4) tick();
    chk("edge4 valid", Valid, 0);
    chk("edge4 count", Count, 0);
    tick();
    chk("edge5 valid", Valid, 1);
    chk("edge5 count", Count, 3);
    chk("edge5 wrap", Wrap, 0);
    chk("edge5 err", Err, 0);
    tick();
    chk("edge6 hex0", HEX0, 7'h30);
    apply_rows(0, 6);
    Q_in = 3'd5;
    tick();
    Q_in = 3'd2;
    repeat (6) tick();
    chk("glitch count", Count, 8'h0A);
    chk("glitch err", Err, 0);
    Q_in = 3'd1;
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    chk("clr1 count", Count, 0);
    chk("clr1 valid", Valid, 0);
    repeat (6) tick();
    chk("base1 count", Count, 1);
    chk("base1 valid", Valid, 1);
    Q_in = 3'd4;
    wraps = 0;
    repeat (6) tick();
    chk("fault err", Err, 1);
    chk("fault count", Count, 1);
    chk("fault wraps", wraps, 0);
    Q_in = 3'd5;
    repeat (6) tick();
    chk("ignored count", Count, 1);
    chk("ignored err", Err, 1);
    chk("ignored valid", Valid, 1);
    Q_in = 3'd0;
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    chk("clr2 count", Count, 0);
    chk("clr2 valid", Valid, 0);
    chk("clr2 err", Err, 0);
    repeat (6) tick();
    chk("base0 count", Count, 0);
    chk("base0 valid", Valid, 1);
    wraps = 0;
    for (int k = 0; k < 31; k++)
      for (int v = 1; v <= 8; v++) begin
        Q_in = 3'(v);
        repeat (4) tick();
      end
    repeat (2) tick();
    chk("pre count", Count, 8'hF8);
    chk("pre wraps", wraps, 31);
    chk("pre ovf", Ovf, 0);
    chk("pre hex0", HEX0, 7'h00);
    chk("pre hex1", HEX1, 7'h0E);
    apply_rows(7, 15);
    for (int v = 2; v <= 7; v++) begin
      Q_in = 3'(v);
      repeat (6) tick();
    end
    chk("pend count", Count, 7);
    Q_in = 3'd0;
    wraps = 0;
    repeat (4) tick();
    chk("pend hold", Count, 7);
    Resetn = 1'b0;
    Clear = 1'b1;
    tick();
    chk("abort count", Count, 0);
    chk("abort valid", Valid, 0);
    chk("abort wrap", Wrap, 0);
    chk("abort err", Err, 0);
    chk("abort ovf", Ovf, 0);
    chk("abort hex0", HEX0, 7'h40);
    chk("abort hex1", HEX1, 7'h40);
    tick();
    Resetn = 1'b1;
    Clear = 1'b0;
    repeat (5) tick();
    chk("post count", Count, 0);
    chk("post valid", Valid, 1);
    chk("post wraps", wraps, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
